lab1_sys_pio_event_ctrl: RTL and testbench
==========================================

LAB1_SYS_PIO_EVENT_CTRL -- requirements
Module: lab1_sys_pio_event_ctrl

Interface
REQ-001 Parameter DEPTH, default 8, event FIFO entries; power of two, range 2..16.
REQ-002 Parameter MASK_INIT, default 8'hFF, irq_mask value written to the PIO after reset.
REQ-003 clk  in  1  single system clock; all logic on its rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 pio_irq  in  1  level interrupt from the PIO (edge_capture & irq_mask nonzero).
REQ-006 m_address  out  2  PIO register select (2 = irq_mask, 3 = edge_capture).
REQ-007 m_chipselect  out  1  PIO access strobe.
REQ-008 m_write_n  out  1  PIO write strobe, active-low.
REQ-009 m_writedata  out  32  PIO write data.
REQ-010 m_readdata  in  32  PIO read data; valid one cycle after the address is presented.
REQ-011 s_address  in  2  CPU register select.
REQ-012 s_chipselect, s_read, s_write_n  in  1 each  CPU access strobes.
REQ-013 s_writedata  in  32  CPU write data.
REQ-014 s_readdata  out  32  CPU read data, registered, one-cycle latency.
REQ-015 irq  out  1  CPU interrupt: high while FIFO is non-empty and ctrl.ien = 1.

Function
REQ-016 FSM states: INIT, IDLE, RD_ADDR, RD_DATA, WAIT_SPACE; encoding is free.
REQ-017 INIT: one cycle with m_chipselect=1, m_write_n=0, m_address=2, m_writedata={24'b0,mask_reg}; next state IDLE.
REQ-018 IDLE: if mask_dirty=1, go to INIT (highest priority); else if pio_irq=1, go to RD_ADDR; else stay.
REQ-019 RD_ADDR: drive m_chipselect=1, m_write_n=1, m_address=3 for one cycle; next RD_DATA.
REQ-020 RD_DATA: latch cap = m_readdata[7:0]; if cap=0, return to IDLE with no write.
REQ-021 Nonzero cap with FIFO not full: push cap and issue a W1C write (m_address=3, m_writedata={24'b0,cap}) in the same cycle; next IDLE.
REQ-022 Nonzero cap with FIFO full: go to WAIT_SPACE and issue no write, so the PIO keeps accumulating edges.
REQ-023 WAIT_SPACE: when the FIFO is not full, including space freed by a pop in the same cycle, go to RD_ADDR to re-read the fresh capture.
REQ-024 Outside the INIT/RD_ADDR/W1C cycles, m_chipselect=0, m_write_n=1, m_address=0, m_writedata=0.
REQ-025 CPU reg 0 (read): FIFO head in bits [7:0]; the read pops when non-empty; reading while empty returns 0 and does not pop.
REQ-026 CPU reg 1 (read): bit0 empty, bit1 full, bits[8:4] count, bit16 lost; all other bits 0.
REQ-027 CPU reg 2: read returns mask_reg; write loads writedata[7:0] and sets mask_dirty.
REQ-028 CPU reg 3: bit0 ien (read/write); writing bit1=1 flushes the FIFO and clears lost.
REQ-029 Simultaneous push and pop: count is unchanged and head/tail pointers both advance; pointers wrap modulo DEPTH.
REQ-030 Flush in the same cycle as a push: flush wins and the pushed event is discarded, setting lost=1.
REQ-031 mask_dirty clears in the INIT cycle; a mask write during INIT re-sets it.
REQ-032 CPU accesses to unused bits or writes to read-only registers have no effect.

Reset
REQ-033 On reset_n=0, asynchronously: FSM=INIT, FIFO empty, pointers=0, mask_reg=MASK_INIT, mask_dirty=0, ien=0, lost=0, s_readdata=0, master outputs idle per REQ-024.
REQ-034 Reset asserted mid-access aborts the access; after release, exactly one INIT write occurs before any capture read.

Structure
REQ-035 Package lab1_sys_pio_event_pkg holds PIO register offsets, CPU register offsets, and the FSM state enum.
REQ-036 One sub-module, lab1_sys_pio_event_fifo (DEPTH x 8, synchronous push/pop/flush, count/full/empty), instantiated once.

Verification
REQ-037 Release reset -> cycle 1 shows one PIO write to address 2 with data 0x000000FF; no further writes while pio_irq=0.
REQ-038 pio_irq=1 with capture 0x05 -> read addr 3, then W1C write of 0x05; FIFO count 1; irq=1 after ien=1; CPU reg 0 returns 0x05 and count returns to 0.
REQ-039 Push 8 events with none popped, then capture 0x10 -> no W1C, FSM in WAIT_SPACE; after one pop, re-read and push 0x10; count=8.
REQ-040 Pop and push in the same cycle at count 3 -> count stays 3 and FIFO order is preserved across pointer wrap.
REQ-041 CPU writes 0x0C to reg 2 while FSM is in RD_DATA -> next IDLE enters INIT and writes 0x0C to PIO address 2.
REQ-042 Assert reset during WAIT_SPACE with 8 queued events -> FIFO empty, irq=0, INIT write repeated after release.

Source files
------------

// File: rtl/lab1_sys_pio_event_pkg.sv
// lab1_sys_pio_event_pkg: register offsets and FSM states shared by the PIO event controller
package lab1_sys_pio_event_pkg;
  localparam logic [1:0] PIO_IRQ_MASK = 2'd2;
  localparam logic [1:0] PIO_EDGE_CAP = 2'd3;
  localparam logic [1:0] CPU_DATA = 2'd0;
  localparam logic [1:0] CPU_STATUS = 2'd1;
  localparam logic [1:0] CPU_MASK = 2'd2;
  localparam logic [1:0] CPU_CTRL = 2'd3;
  typedef enum logic [2:0] {ST_INIT, ST_IDLE, ST_RD_ADDR, ST_RD_DATA, ST_WAIT_SPACE} state_t;
endpackage

// File: rtl/lab1_sys_pio_event_ctrl_if.sv
// lab1_sys_pio_event_ctrl_if: memory-mapped register bus used for both the PIO and CPU sides
interface lab1_sys_pio_event_ctrl_if;
  logic [1:0] address;
  logic chipselect;
  logic read;
  logic write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  modport master(output address, chipselect, read, write_n, writedata, input readdata);
  modport slave(input address, chipselect, read, write_n, writedata, output readdata);
endinterface

// File: rtl/lab1_sys_pio_event_fifo.sv
// lab1_sys_pio_event_fifo: DEPTH x 8 event queue with synchronous push/pop/flush
module lab1_sys_pio_event_fifo #(
  parameter int DEPTH = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic push,
  input  logic [7:0] din,
  input  logic pop,
  input  logic flush,
  output logic [7:0] dout,
  output logic [$clog2(DEPTH):0] count,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign do_push = push & (~full | pop);
  assign do_pop = pop & ~empty;
  assign dout = mem[rd_ptr];
  // pointers and occupancy; flush discards everything including a same-cycle push
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= do_push ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr <= do_pop ? rd_ptr + 1'b1 : rd_ptr;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  // storage array, no reset needed since occupancy guards reads
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/lab1_sys_pio_event_ctrl.sv
// lab1_sys_pio_event_ctrl: drains PIO edge captures into a FIFO and exposes them to the CPU
module lab1_sys_pio_event_ctrl
  import lab1_sys_pio_event_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter logic [7:0] MASK_INIT = 8'hFF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pio_irq,
  lab1_sys_pio_event_ctrl_if.master m,
  lab1_sys_pio_event_ctrl_if.slave s,
  output logic irq
);
  localparam int CW = $clog2(DEPTH) + 1;
  state_t state, state_nx;
  logic [7:0] mask_reg, head, cap;
  logic mask_dirty, ien, lost, push, pop, flush, full, empty, rd, wr, m_cs, m_wn;
  logic [CW-1:0] count;
  logic [1:0] m_addr;
  logic [31:0] m_wd, status, rd_mux;
  logic unused;
  assign cap = m.readdata[7:0];
  assign rd = s.chipselect & s.read;
  assign wr = s.chipselect & ~s.write_n;
  assign pop = rd & (s.address == CPU_DATA) & ~empty;
  assign flush = wr & (s.address == CPU_CTRL) & s.writedata[1];
  assign irq = ien & ~empty;
  assign status = {15'b0, lost, 7'b0, 5'(count), 2'b0, full, empty};
  assign unused = ^{m.readdata[31:8], s.writedata[31:8]};
  lab1_sys_pio_event_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .reset_n(reset_n),
    .push(push),
    .din(cap),
    .pop(pop),
    .flush(flush),
    .dout(head),
    .count(count),
    .full(full),
    .empty(empty)
  );
  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_INIT;
    else state <= state_nx;
  end
  // next state and PIO bus strobes
  always_comb begin
    state_nx = state;
    m_cs = 1'b0;
    m_wn = 1'b1;
    m_addr = 2'd0;
    m_wd = '0;
    push = 1'b0;
    case (state)
      ST_INIT: begin
        m_cs = 1'b1;
        m_wn = 1'b0;
        m_addr = PIO_IRQ_MASK;
        m_wd = {24'b0, mask_reg};
        state_nx = ST_IDLE;
      end
      ST_IDLE: state_nx = mask_dirty ? ST_INIT : pio_irq ? ST_RD_ADDR : ST_IDLE;
      ST_RD_ADDR: begin
        m_cs = 1'b1;
        m_addr = PIO_EDGE_CAP;
        state_nx = ST_RD_DATA;
      end
      ST_RD_DATA: begin
        if (cap == '0) state_nx = ST_IDLE;
        else if (full) state_nx = ST_WAIT_SPACE;
        else begin
          m_cs = 1'b1;
          m_wn = 1'b0;
          m_addr = PIO_EDGE_CAP;
          m_wd = {24'b0, cap};
          push = 1'b1;
          state_nx = ST_IDLE;
        end
      end
      ST_WAIT_SPACE: state_nx = (!full || pop) ? ST_RD_ADDR : ST_WAIT_SPACE;
      default: state_nx = ST_INIT;
    endcase
  end
  // the FSM rests in INIT during reset, so the bus is forced idle until release
  assign m.chipselect = m_cs & reset_n;
  assign m.write_n = m_wn | ~reset_n;
  assign m.address = reset_n ? m_addr : 2'd0;
  assign m.writedata = reset_n ? m_wd : '0;
  assign m.read = m.chipselect & m.write_n;
  // CPU control registers; a mask write during INIT re-arms mask_dirty
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_reg <= MASK_INIT;
      mask_dirty <= 1'b0;
      ien <= 1'b0;
      lost <= 1'b0;
    end else begin
      if (state == ST_INIT) mask_dirty <= 1'b0;
      if (wr && s.address == CPU_MASK) begin
        mask_reg <= s.writedata[7:0];
        mask_dirty <= 1'b1;
      end
      if (wr && s.address == CPU_CTRL) ien <= s.writedata[0];
      if (flush) lost <= push;
    end
  end
  // CPU read mux
  always_comb begin
    rd_mux = (s.address == CPU_DATA) ? (empty ? 32'd0 : {24'b0, head}) :
             (s.address == CPU_STATUS) ? status :
             (s.address == CPU_MASK) ? {24'b0, mask_reg} : {31'b0, ien};
  end
  // registered CPU read data
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) s.readdata <= '0;
    else s.readdata <= rd ? rd_mux : '0;
  end
endmodule

// File: tb/tb_lab1_sys_pio_event_ctrl.sv
// tb_lab1_sys_pio_event_ctrl: self-checking bench with a PIO model and FIFO scoreboard
module tb_lab1_sys_pio_event_ctrl;
  import lab1_sys_pio_event_pkg::*;
  typedef struct packed {logic wr; logic [1:0] addr; logic [31:0] data;} acc_t;
  typedef struct {logic [7:0] cap; logic [31:0] exp_status;} vec_t;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic pio_irq, irq;
  logic [7:0] pio_cap = 8'h00;
  logic [7:0] pio_mask = 8'h00;
  logic [7:0] edge_in = 8'h00;
  acc_t acc_q[$];
  logic [7:0] sb[$];
  int total = 0;
  int bad = 0;
  lab1_sys_pio_event_ctrl_if m_if();
  lab1_sys_pio_event_ctrl_if s_if();
  lab1_sys_pio_event_ctrl dut (
    .clk(clk),
    .reset_n(reset_n),
    .pio_irq(pio_irq),
    .m(m_if),
    .s(s_if),
    .irq(irq)
  );
  always #5 clk = ~clk;
  assign pio_irq = |(pio_cap & pio_mask);
  // PIO model: edge capture with W1C, irq mask register, one-cycle read latency
  always @(posedge clk) begin
    if (m_if.chipselect && m_if.write_n && m_if.address == 2'd3) m_if.readdata <= {24'b0, pio_cap};
    if (m_if.chipselect && !m_if.write_n && m_if.address == 2'd3) pio_cap <= (pio_cap & ~m_if.writedata[7:0]) | edge_in;
    else pio_cap <= pio_cap | edge_in;
    if (m_if.chipselect && !m_if.write_n && m_if.address == 2'd2) pio_mask <= m_if.writedata[7:0];
  end
  // bus monitor logging every PIO access
  always @(posedge clk) begin
    if (reset_n && m_if.chipselect) acc_q.push_back({~m_if.write_n, m_if.address, m_if.writedata});
  end
  initial begin
    #400000;
    $display("FAIL global_timeout: got no finish, want finish");
    $fatal(1);
  end
  function automatic logic [31:0] stat(input int cnt, input logic lst);
    return {15'b0, lst, 7'b0, 5'(cnt), 2'b0, cnt == 8, cnt == 0};
  endfunction
  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  task automatic expect_acc(input string nm, input logic w, input logic [1:0] a, input logic [31:0] d);
    acc_t x;
    int n = 0;
    while (acc_q.size() == 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (acc_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: got no PIO access want %0h", nm, {w, a, d});
    end else begin
      x = acc_q.pop_front();
      check(nm, 64'(x), 64'({w, a, d}));
    end
  endtask
  task automatic cpu_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    s_if.chipselect = 1'b1;
    s_if.read = 1'b1;
    s_if.address = a;
    @(negedge clk);
    s_if.chipselect = 1'b0;
    s_if.read = 1'b0;
    d = s_if.readdata;
  endtask
  task automatic cpu_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    s_if.chipselect = 1'b1;
    s_if.write_n = 1'b0;
    s_if.address = a;
    s_if.writedata = d;
    @(negedge clk);
    s_if.chipselect = 1'b0;
    s_if.write_n = 1'b1;
  endtask
  task automatic inject(input logic [7:0] c);
    @(negedge clk);
    edge_in = c;
    @(negedge clk);
    edge_in = 8'h00;
  endtask
  task automatic wait_rd_addr();
    int n = 0;
    while (!(m_if.chipselect && m_if.write_n && m_if.address == 2'd3) && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (n >= 30) begin
      total++;
      bad++;
      $display("FAIL wait_rd_addr: got no capture read want one");
    end
  endtask
  task automatic capture(input logic [7:0] c);
    inject(c);
    expect_acc("cap_rd", 1'b0, 2'd3, 32'd0);
    expect_acc("w1c", 1'b1, 2'd3, {24'b0, c});
    sb.push_back(c);
  endtask
  task automatic drain(input int n);
    logic [31:0] d;
    logic [7:0] e;
    for (int i = 0; i < n; i++) begin
      e = sb.size() > 0 ? sb.pop_front() : 8'h00;
      cpu_read(2'd0, d);
      check("fifo_data", 64'(d), 64'({24'b0, e}));
    end
  endtask
  initial begin
    vec_t tbl[4];
    logic [31:0] d;
    tbl[0] = '{8'h05, stat(1, 1'b0)};
    tbl[1] = '{8'h30, stat(2, 1'b0)};
    tbl[2] = '{8'h81, stat(3, 1'b0)};
    tbl[3] = '{8'hC3, stat(4, 1'b0)};
    s_if.chipselect = 1'b0;
    s_if.read = 1'b0;
    s_if.write_n = 1'b1;
    s_if.address = 2'd0;
    s_if.writedata = '0;
    m_if.readdata = '0;
    repeat (3) @(negedge clk);
    check("rst_cs", 64'(m_if.chipselect), 64'd0);
    check("rst_irq", 64'(irq), 64'd0);
    check("rst_rdata", 64'(s_if.readdata), 64'd0);
    reset_n = 1'b1;
    #1;
    check("init_bus", 64'({m_if.chipselect, m_if.write_n, m_if.address, m_if.writedata}), 64'({1'b1, 1'b0, 2'd2, 32'hFF}));
    expect_acc("init_wr", 1'b1, 2'd2, 32'hFF);
    repeat (10) @(negedge clk);
    check("idle_quiet", 64'(acc_q.size()), 64'd0);
    check("pio_mask", 64'(pio_mask), 64'hFF);
    for (int i = 0; i < 4; i++) begin
      capture(tbl[i].cap);
      cpu_read(2'd1, d);
      check("tbl_status", 64'(d), 64'(tbl[i].exp_status));
    end
    check("irq_off", 64'(irq), 64'd0);
    cpu_write(2'd3, 32'h1);
    check("irq_on", 64'(irq), 64'd1);
    cpu_read(2'd3, d);
    check("ctrl_rd", 64'(d), 64'd1);
    drain(4);
    cpu_read(2'd1, d);
    check("drained", 64'(d), 64'(stat(0, 1'b0)));
    check("irq_empty", 64'(irq), 64'd0);
    cpu_read(2'd0, d);
    check("empty_rd", 64'(d), 64'd0);
    inject(8'h44);
    wait_rd_addr();
    cpu_write(2'd2, 32'h0C);
    expect_acc("m_rd", 1'b0, 2'd3, 32'd0);
    expect_acc("m_w1c", 1'b1, 2'd3, 32'h44);
    expect_acc("m_init", 1'b1, 2'd2, 32'h0C);
    sb.push_back(8'h44);
    check("pio_mask_0c", 64'(pio_mask), 64'h0C);
    cpu_read(2'd2, d);
    check("mask_rd", 64'(d), 64'h0C);
    cpu_write(2'd2, 32'hFF);
    expect_acc("m_restore", 1'b1, 2'd2, 32'hFF);
    drain(1);
    for (int i = 0; i < 8; i++) capture(8'(i * 17 + 3));
    cpu_read(2'd1, d);
    check("full_status", 64'(d), 64'(stat(8, 1'b0)));
    inject(8'h10);
    expect_acc("ws_rd", 1'b0, 2'd3, 32'd0);
    repeat (8) @(negedge clk);
    check("ws_no_write", 64'(acc_q.size()), 64'd0);
    check("ws_state", 64'(dut.state), 64'(ST_WAIT_SPACE));
    check("ws_pio_cap", 64'(pio_cap), 64'h10);
    drain(1);
    expect_acc("ws_reread", 1'b0, 2'd3, 32'd0);
    expect_acc("ws_w1c", 1'b1, 2'd3, 32'h10);
    sb.push_back(8'h10);
    cpu_read(2'd1, d);
    check("ws_status", 64'(d), 64'(stat(8, 1'b0)));
    drain(5);
    inject(8'h5A);
    wait_rd_addr();
    cpu_read(2'd0, d);
    check("pp_data", 64'(d), 64'({24'b0, sb.pop_front()}));
    sb.push_back(8'h5A);
    expect_acc("pp_rd", 1'b0, 2'd3, 32'd0);
    expect_acc("pp_w1c", 1'b1, 2'd3, 32'h5A);
    cpu_read(2'd1, d);
    check("pp_status", 64'(d), 64'(stat(3, 1'b0)));
    drain(3);
    for (int i = 0; i < 8; i++) capture(8'(i * 13 + 7));
    inject(8'h22);
    expect_acc("rs_ws_rd", 1'b0, 2'd3, 32'd0);
    repeat (4) @(negedge clk);
    check("rs_irq_pre", 64'(irq), 64'd1);
    reset_n = 1'b0;
    #1;
    check("rs_irq", 64'(irq), 64'd0);
    check("rs_cs", 64'(m_if.chipselect), 64'd0);
    sb.delete();
    acc_q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    expect_acc("rs_init", 1'b1, 2'd2, 32'hFF);
    expect_acc("rs_rd", 1'b0, 2'd3, 32'd0);
    expect_acc("rs_w1c", 1'b1, 2'd3, 32'h22);
    sb.push_back(8'h22);
    cpu_read(2'd1, d);
    check("rs_status", 64'(d), 64'(stat(1, 1'b0)));
    check("rs_ien", 64'(irq), 64'd0);
    drain(1);
    inject(8'h66);
    wait_rd_addr();
    cpu_write(2'd3, 32'h2);
    expect_acc("fl_rd", 1'b0, 2'd3, 32'd0);
    expect_acc("fl_w1c", 1'b1, 2'd3, 32'h66);
    cpu_read(2'd1, d);
    check("fl_lost", 64'(d), 64'(stat(0, 1'b1)));
    cpu_write(2'd3, 32'h2);
    cpu_read(2'd1, d);
    check("fl_clear", 64'(d), 64'(stat(0, 1'b0)));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
